// File: rtl/ir_pkg.sv
// Shared definitions for the pulse-distance IR decoder: state and error
// encodings plus the duration window test.
package ir_pkg;

  typedef enum logic [3:0] {
    ST_IDLE       = 4'd0,
    ST_SYNC_BURST = 4'd1,
    ST_SYNC_SIL   = 4'd2,
    ST_BIT_BURST  = 4'd3,
    ST_BIT_SIL    = 4'd4,
    ST_RPT_DIP    = 4'd5
  } ir_state_e;

  localparam logic [2:0] ERR_NONE       = 3'd0;
  localparam logic [2:0] ERR_SYNC_BURST = 3'd1;
  localparam logic [2:0] ERR_SYNC_SIL   = 3'd2;
  localparam logic [2:0] ERR_BIT_BURST  = 3'd3;
  localparam logic [2:0] ERR_BIT_SIL    = 3'd4;
  localparam logic [2:0] ERR_TIMEOUT    = 3'd5;

  // Inclusive nom +/- margin test, written without subtraction so small
  // nominal values cannot underflow.
  function automatic logic in_window(input int unsigned len,
                                     input int unsigned nom,
                                     input int unsigned margin);
    return ((len + margin) >= nom) && (len <= (nom + margin));
  endfunction

endpackage

// File: rtl/ir_edge_sync.sv
// Two-flop synchroniser for the raw IR pin, polarity normalisation to
// "burst = 1", and one-cycle burst start/end strobes.
module ir_edge_sync #(
  parameter bit ACTIVE_LOW = 1'b1
) (
  input  logic clk,
  input  logic rst_n,
  input  logic signal,
  output logic burst_start,
  output logic burst_end
);

  // Raw pin level when no burst is present.
  localparam logic IDLE_LVL = ACTIVE_LOW;

  logic [1:0] sync;
  logic       burst_now;
  logic       burst_q;

  assign burst_now = sync[1] ^ IDLE_LVL;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync    <= {2{IDLE_LVL}};
      burst_q <= 1'b0;
    end else begin
      sync    <= {sync[0], signal};
      burst_q <= burst_now;
    end
  end

  assign burst_start = burst_now & ~burst_q;
  assign burst_end   = ~burst_now & burst_q;

endmodule

// File: rtl/ir_decoder_rpt.sv
// Pulse-distance IR frame decoder with NEC-style repeat detection and
// classified error reporting.
//
// state      | meaning
// IDLE       | line idle, waiting for a sync burst
// SYNC_BURST | inside the sync burst
// SYNC_SIL   | sync silence; its length selects data frame or repeat
// BIT_BURST  | inside a bit burst (or the final dip once idx==NBITS)
// BIT_SIL    | bit silence; its length selects 0 or 1
// RPT_DIP    | final dip of a repeat frame
module ir_decoder_rpt
  import ir_pkg::*;
#(
  parameter int unsigned NBITS      = 32,
  parameter int unsigned SBD        = 900,
  parameter int unsigned SSD        = 450,
  parameter int unsigned RSD        = 225,
  parameter int unsigned BBD        = 60,
  parameter int unsigned BSD0       = 60,
  parameter int unsigned BSD1       = 160,
  parameter int unsigned MARGIN     = 20,
  parameter bit          ACTIVE_LOW = 1'b1
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             signal_in,
  output logic [NBITS-1:0] code_out,
  output logic             new_code_out,
  output logic             repeat_out,
  output logic [2:0]       error_out,
  output logic [3:0]       state_out
);

  localparam int unsigned CW = $clog2(SBD + MARGIN + 2);
  localparam int unsigned IW = $clog2(NBITS + 1);

  localparam logic [3:0] S_IDLE       = ST_IDLE;
  localparam logic [3:0] S_SYNC_BURST = ST_SYNC_BURST;
  localparam logic [3:0] S_SYNC_SIL   = ST_SYNC_SIL;
  localparam logic [3:0] S_BIT_BURST  = ST_BIT_BURST;
  localparam logic [3:0] S_BIT_SIL    = ST_BIT_SIL;
  localparam logic [3:0] S_RPT_DIP    = ST_RPT_DIP;

  if (!(BSD0 + MARGIN < BSD1 - MARGIN)) begin : g_bad_bsd
    $fatal(1, "ir_decoder_rpt: BSD0/BSD1 windows overlap");
  end
  if (!(RSD + MARGIN < SSD - MARGIN)) begin : g_bad_rsd
    $fatal(1, "ir_decoder_rpt: RSD/SSD windows overlap");
  end
  if (!(MARGIN < BBD)) begin : g_bad_margin
    $fatal(1, "ir_decoder_rpt: MARGIN must be below BBD");
  end
  if ((NBITS < 8) || (NBITS > 64)) begin : g_bad_nbits
    $fatal(1, "ir_decoder_rpt: NBITS out of range");
  end

  logic             burst_start;
  logic             burst_end;
  logic [CW-1:0]    cnt;
  logic [3:0]       state;
  logic [IW-1:0]    idx;
  logic [NBITS-1:0] shreg;
  logic [31:0]      len;
  logic [31:0]      tmax;
  logic             timeout;

  ir_edge_sync #(
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_edge_sync (
    .clk         (clk_in),
    .rst_n       (rst_n_in),
    .signal      (signal_in),
    .burst_start (burst_start),
    .burst_end   (burst_end)
  );

  // Phase length counter: value on an edge is the length of the phase just ended.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (burst_start || burst_end) begin
      cnt <= CW'(1);
    end else if (cnt != '1) begin
      cnt <= cnt + CW'(1);
    end
  end

  assign len = 32'(cnt);

  always_comb begin
    tmax = 32'hFFFF_FFFF;
    case (state)
      S_SYNC_BURST: tmax = SBD + MARGIN;
      S_SYNC_SIL:   tmax = SSD + MARGIN;
      S_BIT_BURST:  tmax = BBD + MARGIN;
      S_BIT_SIL:    tmax = BSD1 + MARGIN;
      S_RPT_DIP:    tmax = BBD + MARGIN;
      default:      tmax = 32'hFFFF_FFFF;
    endcase
  end

  assign timeout = (state != S_IDLE) && (len > tmax);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state        <= S_IDLE;
      idx          <= '0;
      shreg        <= '0;
      code_out     <= '0;
      new_code_out <= 1'b0;
      repeat_out   <= 1'b0;
      error_out    <= ERR_NONE;
    end else begin
      new_code_out <= 1'b0;
      repeat_out   <= 1'b0;
      case (state)
        S_IDLE: begin
          if (burst_start) state <= S_SYNC_BURST;
        end
        S_SYNC_BURST: begin
          if (burst_end) begin
            if (in_window(len, SBD, MARGIN)) begin
              state <= S_SYNC_SIL;
            end else begin
              error_out <= ERR_SYNC_BURST;
              state     <= S_IDLE;
            end
          end else if (timeout) begin
            error_out <= ERR_TIMEOUT;
            state     <= S_IDLE;
          end
        end
        S_SYNC_SIL: begin
          if (burst_start) begin
            if (in_window(len, SSD, MARGIN)) begin
              idx   <= '0;
              state <= S_BIT_BURST;
            end else if (in_window(len, RSD, MARGIN)) begin
              state <= S_RPT_DIP;
            end else begin
              error_out <= ERR_SYNC_SIL;
              state     <= S_IDLE;
            end
          end else if (timeout) begin
            error_out <= ERR_TIMEOUT;
            state     <= S_IDLE;
          end
        end
        S_BIT_BURST: begin
          if (burst_end) begin
            if (!in_window(len, BBD, MARGIN)) begin
              error_out <= ERR_BIT_BURST;
              state     <= S_IDLE;
            end else if (idx == IW'(NBITS)) begin
              // Final dip closes the frame.
              code_out     <= shreg;
              new_code_out <= 1'b1;
              error_out    <= ERR_NONE;
              state        <= S_IDLE;
            end else begin
              state <= S_BIT_SIL;
            end
          end else if (timeout) begin
            error_out <= ERR_TIMEOUT;
            state     <= S_IDLE;
          end
        end
        S_BIT_SIL: begin
          if (burst_start) begin
            if (in_window(len, BSD0, MARGIN)) begin
              shreg <= {shreg[NBITS-2:0], 1'b0};
              idx   <= idx + IW'(1);
              state <= S_BIT_BURST;
            end else if (in_window(len, BSD1, MARGIN)) begin
              shreg <= {shreg[NBITS-2:0], 1'b1};
              idx   <= idx + IW'(1);
              state <= S_BIT_BURST;
            end else begin
              error_out <= ERR_BIT_SIL;
              state     <= S_IDLE;
            end
          end else if (timeout) begin
            error_out <= ERR_TIMEOUT;
            state     <= S_IDLE;
          end
        end
        S_RPT_DIP: begin
          if (burst_end) begin
            if (in_window(len, BBD, MARGIN)) begin
              repeat_out <= 1'b1;
              error_out  <= ERR_NONE;
            end else begin
              error_out <= ERR_BIT_BURST;
            end
            state <= S_IDLE;
          end else if (timeout) begin
            error_out <= ERR_TIMEOUT;
            state     <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign state_out = state;

endmodule

// File: tb/tb_ir_decoder_rpt.sv
// Directed bench for ir_decoder_rpt: a default 32-bit active-low instance
// and a 16-bit active-high instance driven from one linear sequence.
module tb_ir_decoder_rpt;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        sig_a = 1'b1;
  logic        sig_b = 1'b0;

  logic [31:0] code_a;
  logic        new_a, rep_a;
  logic [2:0]  err_a;
  logic [3:0]  st_a;

  logic [15:0] code_b;
  logic        new_b, rep_b;
  logic [2:0]  err_b;
  logic [3:0]  st_b;

  int checks = 0;
  int errors = 0;
  int nc_a = 0, rp_a = 0, nc_b = 0, rp_b = 0, both = 0;
  int nc0, rp0;

  always #5 clk = ~clk;

  ir_decoder_rpt dut_a (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .signal_in    (sig_a),
    .code_out     (code_a),
    .new_code_out (new_a),
    .repeat_out   (rep_a),
    .error_out    (err_a),
    .state_out    (st_a)
  );

  ir_decoder_rpt #(
    .NBITS      (16),
    .ACTIVE_LOW (1'b0)
  ) dut_b (
    .clk_in       (clk),
    .rst_n_in     (rst_n),
    .signal_in    (sig_b),
    .code_out     (code_b),
    .new_code_out (new_b),
    .repeat_out   (rep_b),
    .error_out    (err_b),
    .state_out    (st_b)
  );

  always @(negedge clk) begin
    if (new_a) nc_a++;
    if (rep_a) rp_a++;
    if (new_b) nc_b++;
    if (rep_b) rp_b++;
    if ((new_a && rep_a) || (new_b && rep_b)) both++;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clk(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic line(input int which, input bit burst);
    if (which == 0) sig_a = ~burst;
    else            sig_b = burst;
  endtask

  task automatic phase(input int which, input bit burst, input int n);
    line(which, burst);
    wait_clk(n);
  endtask

  task automatic bit_cell(input int which, input bit b);
    phase(which, 1'b1, 60);
    phase(which, 1'b0, b ? 160 : 60);
  endtask

  // Ends with the line just returned to idle after the final dip.
  task automatic send_frame(input int which, input logic [63:0] code, input int nbits, input int sb);
    phase(which, 1'b1, sb);
    phase(which, 1'b0, 450);
    for (int i = nbits - 1; i >= 0; i--) bit_cell(which, code[i]);
    phase(which, 1'b1, 60);
    line(which, 1'b0);
  endtask

  initial begin
    logic [31:0] c;
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(2);

    check("rst_code",  64'(code_a), 64'h0);
    check("rst_new",   64'(new_a),  64'h0);
    check("rst_rep",   64'(rep_a),  64'h0);
    check("rst_err",   64'(err_a),  64'h0);
    check("rst_state", 64'(st_a),   64'h0);

    // 1: nominal frame with exact pulse latency
    nc0 = nc_a;
    send_frame(0, 64'hDEADBEEF, 32, 900);
    repeat (3) @(negedge clk);
    check("t1_lat_early", 64'(new_a), 64'h0);
    @(negedge clk);
    check("t1_lat_pulse", 64'(new_a), 64'h1);
    @(negedge clk);
    check("t1_lat_end",   64'(new_a), 64'h0);
    wait_clk(20);
    check("t1_code",  64'(code_a), 64'hDEADBEEF);
    check("t1_npulse", 64'(nc_a - nc0), 64'd1);
    check("t1_err",   64'(err_a), 64'h0);
    check("t1_state", 64'(st_a), 64'h0);

    // 2: repeat frame
    nc0 = nc_a; rp0 = rp_a;
    phase(0, 1'b1, 900);
    phase(0, 1'b0, 225);
    phase(0, 1'b1, 60);
    line(0, 1'b0);
    repeat (3) @(negedge clk);
    check("t2_lat_early", 64'(rep_a), 64'h0);
    @(negedge clk);
    check("t2_lat_pulse", 64'(rep_a), 64'h1);
    wait_clk(20);
    check("t2_rpulse", 64'(rp_a - rp0), 64'd1);
    check("t2_nopulse", 64'(nc_a - nc0), 64'd0);
    check("t2_code", 64'(code_a), 64'hDEADBEEF);
    check("t2_err",  64'(err_a), 64'h0);

    // 3: short sync burst, then recovery
    nc0 = nc_a; rp0 = rp_a;
    phase(0, 1'b1, 700);
    phase(0, 1'b0, 30);
    check("t3_err",   64'(err_a), 64'd1);
    check("t3_state", 64'(st_a), 64'h0);
    check("t3_pulses", 64'((nc_a - nc0) + (rp_a - rp0)), 64'd0);
    send_frame(0, 64'hA5A55A5A, 32, 900);
    wait_clk(20);
    check("t3_code", 64'(code_a), 64'hA5A55A5A);
    check("t3_err2", 64'(err_a), 64'h0);

    // 4a: bad bit silence at bit 5
    c = 32'h0F1E2D3C;
    nc0 = nc_a;
    phase(0, 1'b1, 900);
    phase(0, 1'b0, 450);
    for (int k = 0; k < 5; k++) bit_cell(0, c[31-k]);
    phase(0, 1'b1, 60);
    phase(0, 1'b0, 110);
    phase(0, 1'b1, 60);
    phase(0, 1'b0, 20);
    check("t4_err_sil", 64'(err_a), 64'd4);
    check("t4_code",    64'(code_a), 64'hA5A55A5A);

    // 4b: line held idle after bit 20's burst
    phase(0, 1'b1, 900);
    phase(0, 1'b0, 450);
    for (int k = 0; k < 20; k++) bit_cell(0, c[31-k]);
    phase(0, 1'b1, 60);
    phase(0, 1'b0, 30);
    check("t4_mid_state", 64'(st_a), 64'd4);
    wait_clk(200);
    check("t4_err_to",  64'(err_a), 64'd5);
    check("t4_state",   64'(st_a), 64'h0);
    check("t4_nopulse", 64'(nc_a - nc0), 64'd0);

    // 5: reset in the middle of bit 16
    phase(0, 1'b1, 900);
    phase(0, 1'b0, 450);
    for (int k = 0; k < 16; k++) bit_cell(0, c[31-k]);
    phase(0, 1'b1, 60);
    phase(0, 1'b0, 30);
    check("t5_pre_state", 64'(st_a), 64'd4);
    rst_n = 1'b0;
    #2;
    check("t5_rst_code",  64'(code_a), 64'h0);
    check("t5_rst_err",   64'(err_a), 64'h0);
    check("t5_rst_state", 64'(st_a), 64'h0);
    wait_clk(3);
    rst_n = 1'b1;
    wait_clk(5);
    nc0 = nc_a;
    send_frame(0, 64'h0F1E2D3C, 32, 900);
    wait_clk(20);
    check("t5_code",   64'(code_a), 64'h0F1E2D3C);
    check("t5_npulse", 64'(nc_a - nc0), 64'd1);

    // 6: 16-bit active-high instance, sync burst window edges
    nc0 = nc_b;
    send_frame(1, 64'h1234, 16, 920);
    wait_clk(20);
    check("t6_code_920", 64'(code_b), 64'h1234);
    check("t6_npulse",   64'(nc_b - nc0), 64'd1);
    phase(1, 1'b1, 921);
    phase(1, 1'b0, 30);
    check("t6_err_921", 64'(err_b), 64'd1);
    check("t6_state",   64'(st_b), 64'h0);
    send_frame(1, 64'hBEEF, 16, 880);
    wait_clk(20);
    check("t6_code_880", 64'(code_b), 64'hBEEF);
    check("t6_err_clr",  64'(err_b), 64'h0);
    phase(1, 1'b1, 879);
    phase(1, 1'b0, 30);
    check("t6_err_879", 64'(err_b), 64'd1);
    check("t6_code_hold", 64'(code_b), 64'hBEEF);
    check("a_untouched", 64'(code_a), 64'h0F1E2D3C);
    check("pulse_overlap", 64'(both), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
